ah_sample_packer: RTL and testbench
===================================

Name: ah_sample_packer

Overview:
Upstream feeder for the PL2DDR DMA block, sitting in the clk_data domain between the sample source and the DMA's data_in/data_en.
- Accepts narrow samples (SAMPLE_WIDTH) with a per-sample strobe and packs them into DATA_WIDTH words.
- Emits each packed word as a single-cycle data_en pulse.
- Supports a word budget, explicit flush of partial words, and counters the processor can read back.

Parameters:
DATA_WIDTH, 32, output word width; must equal the DMA DATA_WIDTH.
SAMPLE_WIDTH, 8, input sample width; DATA_WIDTH must be an integer multiple of it. N = DATA_WIDTH/SAMPLE_WIDTH samples per word (N >= 1).
LSB_FIRST, 1, 1: first sample of a word lands in bits [SAMPLE_WIDTH-1:0]; 0: first sample lands in the MSB slot.

Ports:
clk_data  in  1  single clock for the whole block; the same clock drives the DMA clk_data.
aresetn  in  1  reset, synchronous, active-low.
enable  in  1  level; high = packing session active.
flush  in  1  single-cycle pulse; emit the partial word, zero-padded.
number_words  in  32  word budget per session; 0 = unlimited. Latched on session start.
sample_in  in  SAMPLE_WIDTH  sample data.
sample_en  in  1  sample_in valid this cycle.
data_out  out  DATA_WIDTH  packed word; connects to DMA data_in.
data_en  out  1  one-cycle strobe, data_out valid; connects to DMA data_en.
fill_level  out  $clog2(N)+1  samples held in the partial word.
words_packed  out  32  words emitted this session.
samples_dropped  out  32  samples received while in DONE.
busy  out  1  high in PACK.
done  out  1  high in DONE.

Behaviour:
Clock and reset:
- One clock: clk_data. Reset is synchronous and active-low (aresetn sampled on the rising edge of clk_data).
- Reset forces state IDLE. All outputs reset to 0: data_out, data_en, fill_level, words_packed, samples_dropped, busy, done.
- aresetn low mid-word discards the partial word; no data_en is issued.

State IDLE:
- Samples are ignored and not counted.
- enable=1 -> PACK. On that transition: clear fill, words_packed and samples_dropped; latch number_words.
- The transition cycle itself accepts no sample. The first sample is accepted the cycle after busy rises.

State PACK:
- Each sample_en=1 writes sample_in into the slot given by fill, ordered per LSB_FIRST, then fill increments.
- When a sample fills slot N-1: the next cycle drives data_out = word and data_en=1 for exactly one cycle, fill returns to 0, and words_packed increments. Latency from final sample to data_en is 1 cycle.
- Back-to-back words with sample_en held high every cycle are allowed: data_en pulses every N cycles. With N=1, data_en follows sample_en with 1-cycle latency and may be high continuously.
- flush with fill>0: the next cycle emits the partial word with unused slots zero, data_en=1, fill becomes 0, words_packed increments.
- flush with fill=0: no-op.
- flush and sample_en in the same cycle: the sample is packed first, then the flush applies. At most one word is emitted; it is full if that sample completed the word, zero-padded otherwise.
- Word budget: when the emitted word makes words_packed equal the latched nonzero budget -> DONE, in the same edge as data_en rises. A flushed partial word counts toward the budget.
- enable=0 -> IDLE. The partial word is discarded without emission; words_packed and samples_dropped hold their values.
- words_packed wraps modulo 2^32 and no flag is raised.

State DONE:
- done=1. Each sample_en increments samples_dropped, saturating at 2^32-1. flush is ignored.
- enable=0 -> IDLE; counters hold until the next session start.

Output behaviour:
- data_out holds its last value when data_en=0.
- busy is 1 exactly in PACK; done is 1 exactly in DONE.

Test Plan:
- Reset under stimulus: aresetn low for 5 cycles with sample_en toggling -> all outputs 0, no data_en.
- Continuous packing: DATA_WIDTH=32, SAMPLE_WIDTH=8, LSB_FIRST=1, enable high, samples 0x01..0x08 on consecutive cycles -> data_en one cycle after samples 4 and 8; words 0x04030201 and 0x08070605; words_packed=2.
- Flush: after 3 samples 0xAA,0xBB,0xCC, pulse flush -> one data_en with word 0x00CCBBAA, fill_level 0.
- Flush with the completing sample: 4th sample and flush in the same cycle -> exactly one data_en, with the full word.
- Budget: number_words=2, then 12 samples -> 2 data_en pulses, done=1, samples_dropped=4. Deassert enable -> IDLE. Reassert -> counters 0.
- MSB ordering: LSB_FIRST=0, samples 0x11,0x22,0x33,0x44 -> word 0x11223344.
- Abort: enable dropped with fill=2 -> no data_en, IDLE, words_packed unchanged.

Source files
------------

// File: rtl/ah_sample_packer.sv
// Packs narrow strobed samples into DATA_WIDTH words for the PL2DDR DMA feed.
// Supports a per-session word budget, explicit flush of partial words and readback counters.
module ah_sample_packer #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned SAMPLE_WIDTH = 8,
    parameter bit          LSB_FIRST    = 1'b1
) (
    input  logic                                         clk_data,
    input  logic                                         aresetn,
    input  logic                                         enable,
    input  logic                                         flush,
    input  logic [31:0]                                  number_words,
    input  logic [SAMPLE_WIDTH-1:0]                      sample_in,
    input  logic                                         sample_en,
    output logic [DATA_WIDTH-1:0]                        data_out,
    output logic                                         data_en,
    output logic [$clog2(DATA_WIDTH/SAMPLE_WIDTH):0]     fill_level,
    output logic [31:0]                                  words_packed,
    output logic [31:0]                                  samples_dropped,
    output logic                                         busy,
    output logic                                         done
);

    localparam int unsigned N  = DATA_WIDTH / SAMPLE_WIDTH;
    localparam int unsigned FW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACK = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [FW-1:0]           fill_q, fill_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    data_en_q, data_en_d;
    logic [31:0]             words_q, words_d;
    logic [31:0]             dropped_q, dropped_d;
    logic [31:0]             budget_q, budget_d;

    logic [FW-1:0]           slot;
    logic [FW-1:0]           acc_fill;
    logic [DATA_WIDTH-1:0]   acc_word;

    // Partial word and fill count as they would stand after absorbing this cycle's sample.
    always_comb begin
        slot     = LSB_FIRST ? fill_q : (FW'(N - 1) - fill_q);
        acc_word = word_q;
        acc_fill = fill_q;
        if (sample_en) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (FW'(i) == slot) begin
                    acc_word[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = sample_in;
                end
            end
            acc_fill = fill_q + FW'(1);
        end
    end

    // Next-state and output computation.
    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        word_d     = word_q;
        data_out_d = data_out_q;
        data_en_d  = 1'b0;
        words_d    = words_q;
        dropped_d  = dropped_q;
        budget_d   = budget_q;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d   = ST_PACK;
                    fill_d    = '0;
                    word_d    = '0;
                    words_d   = '0;
                    dropped_d = '0;
                    budget_d  = number_words;
                end
            end
            ST_PACK: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    fill_d  = '0;
                    word_d  = '0;
                end else if ((acc_fill == FW'(N)) || (flush && (acc_fill != '0))) begin
                    // Buffer is cleared after every emission, so unused slots are already zero.
                    data_out_d = acc_word;
                    data_en_d  = 1'b1;
                    fill_d     = '0;
                    word_d     = '0;
                    words_d    = words_q + 32'd1;
                    if ((budget_q != '0) && (words_d == budget_q)) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    fill_d = acc_fill;
                    word_d = acc_word;
                end
            end
            ST_DONE: begin
                if (sample_en && (dropped_q != '1)) begin
                    dropped_d = dropped_q + 32'd1;
                end
                if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_data) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            fill_q     <= '0;
            word_q     <= '0;
            data_out_q <= '0;
            data_en_q  <= 1'b0;
            words_q    <= '0;
            dropped_q  <= '0;
            budget_q   <= '0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            word_q     <= word_d;
            data_out_q <= data_out_d;
            data_en_q  <= data_en_d;
            words_q    <= words_d;
            dropped_q  <= dropped_d;
            budget_q   <= budget_d;
        end
    end

    assign data_out        = data_out_q;
    assign data_en         = data_en_q;
    assign fill_level      = fill_q;
    assign words_packed    = words_q;
    assign samples_dropped = dropped_q;
    assign busy            = (state_q == ST_PACK);
    assign done            = (state_q == ST_DONE);

endmodule

// File: tb/tb_ah_sample_packer.sv
// Directed self-checking bench for ah_sample_packer (LSB-first and MSB-first instances).
module tb_ah_sample_packer;

    logic        clk_data = 1'b0;
    logic        aresetn;
    logic        enable;
    logic        enable_m;
    logic        flush;
    logic [31:0] number_words;
    logic [7:0]  sample_in;
    logic        sample_en;

    logic [31:0] data_out, data_out_m;
    logic        data_en, data_en_m;
    logic [2:0]  fill_level, fill_level_m;
    logic [31:0] words_packed, words_packed_m;
    logic [31:0] samples_dropped, samples_dropped_m;
    logic        busy, busy_m;
    logic        done, done_m;

    int errors = 0;
    int checks = 0;
    int pulses;

    always #5 clk_data = ~clk_data;

    ah_sample_packer #(.DATA_WIDTH(32), .SAMPLE_WIDTH(8), .LSB_FIRST(1'b1)) dut (
        .clk_data(clk_data), .aresetn(aresetn), .enable(enable), .flush(flush),
        .number_words(number_words), .sample_in(sample_in), .sample_en(sample_en),
        .data_out(data_out), .data_en(data_en), .fill_level(fill_level),
        .words_packed(words_packed), .samples_dropped(samples_dropped),
        .busy(busy), .done(done)
    );

    ah_sample_packer #(.DATA_WIDTH(32), .SAMPLE_WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
        .clk_data(clk_data), .aresetn(aresetn), .enable(enable_m), .flush(flush),
        .number_words(number_words), .sample_in(sample_in), .sample_en(sample_en),
        .data_out(data_out_m), .data_en(data_en_m), .fill_level(fill_level_m),
        .words_packed(words_packed_m), .samples_dropped(samples_dropped_m),
        .busy(busy_m), .done(done_m)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge clk_data);
        #1;
    endtask

    task automatic push(input logic [7:0] s, input logic f);
        sample_in = s;
        sample_en = 1'b1;
        flush     = f;
        step();
        sample_en = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        aresetn      = 1'b0;
        enable       = 1'b0;
        enable_m     = 1'b0;
        flush        = 1'b0;
        number_words = 32'd0;
        sample_in    = 8'h00;
        sample_en    = 1'b0;

        // Reset under toggling stimulus
        for (int i = 0; i < 5; i++) begin
            sample_en = ~sample_en;
            sample_in = 8'(i + 1);
            step();
            chk("rst_data_en", 32'(data_en), 32'd0);
        end
        sample_en = 1'b0;
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_fill", 32'(fill_level), 32'd0);
        chk("rst_words", words_packed, 32'd0);
        chk("rst_dropped", samples_dropped, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        aresetn = 1'b1;
        step();

        // Continuous packing
        enable = 1'b1;
        step();
        chk("start_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            sample_in = 8'(k);
            sample_en = 1'b1;
            step();
            chk("cont_data_en", 32'(data_en), ((k == 4) || (k == 8)) ? 32'd1 : 32'd0);
            if (k == 4) chk("cont_word0", data_out, 32'h04030201);
            if (k == 8) chk("cont_word1", data_out, 32'h08070605);
        end
        sample_en = 1'b0;
        step();
        chk("cont_en_low", 32'(data_en), 32'd0);
        chk("cont_hold", data_out, 32'h08070605);
        chk("cont_words", words_packed, 32'd2);

        // Flush of a partial word
        push(8'hAA, 1'b0);
        push(8'hBB, 1'b0);
        push(8'hCC, 1'b0);
        chk("flush_fill3", 32'(fill_level), 32'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_en", 32'(data_en), 32'd1);
        chk("flush_word", data_out, 32'h00CCBBAA);
        chk("flush_fill0", 32'(fill_level), 32'd0);
        chk("flush_words", words_packed, 32'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_empty_en", 32'(data_en), 32'd0);
        chk("flush_empty_words", words_packed, 32'd3);

        // Flush in the same cycle as the completing sample
        pulses = 0;
        push(8'h10, 1'b0); pulses += int'(data_en);
        push(8'h20, 1'b0); pulses += int'(data_en);
        push(8'h30, 1'b0); pulses += int'(data_en);
        push(8'h40, 1'b1); pulses += int'(data_en);
        chk("fc_word", data_out, 32'h40302010);
        step(); pulses += int'(data_en);
        step(); pulses += int'(data_en);
        chk("fc_pulses", 32'(pulses), 32'd1);
        chk("fc_words", words_packed, 32'd4);

        // Abort with a partial word held
        push(8'h55, 1'b0);
        push(8'h66, 1'b0);
        chk("abort_fill2", 32'(fill_level), 32'd2);
        enable = 1'b0;
        step();
        chk("abort_en", 32'(data_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_words", words_packed, 32'd4);
        chk("abort_fill", 32'(fill_level), 32'd0);
        step();
        chk("abort_en2", 32'(data_en), 32'd0);

        // Word budget
        number_words = 32'd2;
        enable = 1'b1;
        step();
        chk("bud_words0", words_packed, 32'd0);
        chk("bud_busy", 32'(busy), 32'd1);
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            sample_in = 8'(8'h80 + k);
            sample_en = 1'b1;
            step();
            pulses += int'(data_en);
        end
        sample_en = 1'b0;
        step();
        pulses += int'(data_en);
        chk("bud_pulses", 32'(pulses), 32'd2);
        chk("bud_done", 32'(done), 32'd1);
        chk("bud_busy_low", 32'(busy), 32'd0);
        chk("bud_dropped", samples_dropped, 32'd4);
        chk("bud_words", words_packed, 32'd2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("bud_flush_ign", 32'(data_en), 32'd0);
        enable = 1'b0;
        step();
        chk("bud_idle_done", 32'(done), 32'd0);
        chk("bud_idle_dropped", samples_dropped, 32'd4);
        chk("bud_idle_words", words_packed, 32'd2);
        enable = 1'b1;
        step();
        chk("bud_re_words", words_packed, 32'd0);
        chk("bud_re_dropped", samples_dropped, 32'd0);
        enable = 1'b0;
        number_words = 32'd0;
        step();

        // MSB-first ordering on the second instance
        enable_m = 1'b1;
        step();
        chk("msb_busy", 32'(busy_m), 32'd1);
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b0);
        chk("msb_en_pre", 32'(data_en_m), 32'd0);
        push(8'h44, 1'b0);
        chk("msb_en", 32'(data_en_m), 32'd1);
        chk("msb_word", data_out_m, 32'h11223344);
        chk("msb_words", words_packed_m, 32'd1);
        chk("msb_main_idle", 32'(data_en), 32'd0);
        enable_m = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
